// File: rtl/video_pkg.sv
// Shared widths, CPU-port FSM states and the backdrop address for the palette arbiter.
package video_pkg;

    localparam int PAL_ADDR_W  = 5;
    localparam int PAL_COLOR_W = 6;

    localparam logic [PAL_ADDR_W-1:0] BACKDROP_ADDR = 5'h00;

    typedef enum logic [1:0] {
        CPU_IDLE  = 2'd0,
        CPU_ISSUE = 2'd1,
        CPU_WAIT  = 2'd2,
        CPU_ACK   = 2'd3
    } cpu_state_e;

endpackage

// File: rtl/video_palette_arbiter_if.sv
// CPU, renderer and palette-RAM signal bundle; slave is the arbiter, master is whatever drives it.
interface video_palette_arbiter_if;
    import video_pkg::*;

    logic                   I_cpu_req;
    logic                   I_cpu_wren;
    logic [PAL_ADDR_W-1:0]  I_cpu_addr;
    logic [PAL_COLOR_W-1:0] I_cpu_data;
    logic                   O_cpu_ack;
    logic [PAL_COLOR_W-1:0] O_cpu_data;

    logic                   I_pix_valid;
    logic [PAL_ADDR_W-1:0]  I_pix_index;
    logic                   O_pix_valid;
    logic [PAL_COLOR_W-1:0] O_pix_color;
    logic                   O_pix_stolen;

    logic [PAL_ADDR_W-1:0]  O_pal_addr;
    logic                   O_pal_wren;
    logic [PAL_COLOR_W-1:0] O_pal_data;
    logic [PAL_COLOR_W-1:0] I_pal_data;

    modport slave (
        input  I_cpu_req, I_cpu_wren, I_cpu_addr, I_cpu_data,
        input  I_pix_valid, I_pix_index, I_pal_data,
        output O_cpu_ack, O_cpu_data, O_pix_valid, O_pix_color, O_pix_stolen,
        output O_pal_addr, O_pal_wren, O_pal_data
    );

    modport master (
        output I_cpu_req, I_cpu_wren, I_cpu_addr, I_cpu_data,
        output I_pix_valid, I_pix_index, I_pal_data,
        input  O_cpu_ack, O_cpu_data, O_pix_valid, O_pix_color, O_pix_stolen,
        input  O_pal_addr, O_pal_wren, O_pal_data
    );

endinterface

// File: rtl/video_palette_remap.sv
// Combinational address remap: renderer backdrop folding and, with VIDEO_PAL_MIRROR_EN,
// CPU mirroring of 0x10/0x14/0x18/0x1C onto 0x00/0x04/0x08/0x0C.
module video_palette_remap
    import video_pkg::*;
(
    input  logic [PAL_ADDR_W-1:0] i_cpu_addr,
    input  logic [PAL_ADDR_W-1:0] i_pix_index,
    output logic [PAL_ADDR_W-1:0] o_cpu_addr,
    output logic [PAL_ADDR_W-1:0] o_pix_addr
);

    assign o_pix_addr = (i_pix_index[1:0] == 2'b00) ? BACKDROP_ADDR : i_pix_index;

`ifdef VIDEO_PAL_MIRROR_EN
    assign o_cpu_addr = (i_cpu_addr[4] && (i_cpu_addr[1:0] == 2'b00))
                        ? {1'b0, i_cpu_addr[3:0]} : i_cpu_addr;
`else
    assign o_cpu_addr = i_cpu_addr;
`endif

endmodule

// File: rtl/video_palette_arbiter.sv
// Single-port palette arbiter: renderer has priority, a starved CPU request steals one slot.
// Optional CPU mirror addressing is enabled by defining VIDEO_PAL_MIRROR_EN.
module video_palette_arbiter
    import video_pkg::*;
#(
    parameter int STARVE_MAX = 16
)(
    input  logic                   I_clock,
    input  logic                   I_reset,
    video_palette_arbiter_if.slave bus
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    cpu_state_e             r_state;
    cpu_state_e             w_state_next;
    logic                   r_cpu_wren;
    logic [PAL_ADDR_W-1:0]  r_cpu_addr;
    logic [PAL_COLOR_W-1:0] r_cpu_data;
    logic [7:0]             r_starve;
    logic                   r_s1_valid, r_s1_stolen, r_s2_valid, r_s2_stolen;
    logic                   r_pix_valid, r_pix_stolen;
    logic [PAL_COLOR_W-1:0] r_pix_color;
    logic [PAL_ADDR_W-1:0]  r_pal_addr;
    logic                   r_pal_wren;
    logic [PAL_COLOR_W-1:0] r_pal_data;
    logic                   r_cpu_ack;
    logic [PAL_COLOR_W-1:0] r_cpu_rdata;

    logic                   w_pix_grant, w_cpu_grant, w_accept;
    logic [PAL_ADDR_W-1:0]  w_cpu_addr_map, w_pix_addr_map;

    video_palette_remap u_remap (
        .i_cpu_addr  (r_cpu_addr),
        .i_pix_index (bus.I_pix_index),
        .o_cpu_addr  (w_cpu_addr_map),
        .o_pix_addr  (w_pix_addr_map)
    );

    assign w_pix_grant = bus.I_pix_valid && (r_starve < STARVE_LIM);
    assign w_cpu_grant = (r_state == CPU_ISSUE) && !w_pix_grant;
    // A read ack lands while already back in IDLE; the requester still holds req that cycle.
    assign w_accept    = (r_state == CPU_IDLE) && bus.I_cpu_req && !r_cpu_ack;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CPU_IDLE:  if (w_accept)    w_state_next = CPU_ISSUE;
            CPU_ISSUE: if (w_cpu_grant) w_state_next = CPU_WAIT;
            CPU_WAIT:                   w_state_next = CPU_ACK;
            CPU_ACK:                    w_state_next = CPU_IDLE;
            default:                    w_state_next = CPU_IDLE;
        endcase
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            r_state      <= CPU_IDLE;
            r_cpu_wren   <= 1'b0;
            r_cpu_addr   <= '0;
            r_cpu_data   <= '0;
            r_starve     <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_stolen  <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_s2_stolen  <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_pix_stolen <= 1'b0;
            r_pix_color  <= '0;
            r_pal_addr   <= '0;
            r_pal_wren   <= 1'b0;
            r_pal_data   <= '0;
            r_cpu_ack    <= 1'b0;
            r_cpu_rdata  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cpu_wren <= bus.I_cpu_wren;
                r_cpu_addr <= bus.I_cpu_addr;
                r_cpu_data <= bus.I_cpu_data;
            end

            if ((r_state != CPU_ISSUE) || w_cpu_grant)
                r_starve <= '0;
            else if (w_pix_grant && (r_starve < STARVE_LIM))
                r_starve <= r_starve + 8'd1;

            r_pal_wren <= 1'b0;
            if (w_pix_grant) begin
                r_pal_addr <= w_pix_addr_map;
            end else if (w_cpu_grant) begin
                r_pal_addr <= w_cpu_addr_map;
                r_pal_wren <= r_cpu_wren;
                r_pal_data <= r_cpu_data;
            end

            // A pixel that lost its slot still emerges, repeating the last real color.
            r_s1_valid   <= bus.I_pix_valid;
            r_s1_stolen  <= bus.I_pix_valid && !w_pix_grant;
            r_s2_valid   <= r_s1_valid;
            r_s2_stolen  <= r_s1_stolen;
            r_pix_valid  <= r_s2_valid;
            r_pix_stolen <= r_s2_valid && r_s2_stolen;
            if (r_s2_valid && !r_s2_stolen)
                r_pix_color <= bus.I_pal_data;

            r_cpu_ack <= ((r_state == CPU_WAIT) && r_cpu_wren) ||
                         ((r_state == CPU_ACK)  && !r_cpu_wren);
            if ((r_state == CPU_ACK) && !r_cpu_wren)
                r_cpu_rdata <= bus.I_pal_data;
        end
    end

    assign bus.O_cpu_ack    = r_cpu_ack;
    assign bus.O_cpu_data   = r_cpu_rdata;
    assign bus.O_pix_valid  = r_pix_valid;
    assign bus.O_pix_color  = r_pix_color;
    assign bus.O_pix_stolen = r_pix_stolen;
    assign bus.O_pal_addr   = r_pal_addr;
    assign bus.O_pal_wren   = r_pal_wren;
    assign bus.O_pal_data   = r_pal_data;

endmodule

// File: tb/tb_video_palette_arbiter.sv
// Scoreboard bench for video_palette_arbiter with a behavioural palette RAM.
module tb_video_palette_arbiter;
    import video_pkg::*;

    typedef struct {
        int       due;
        logic [5:0] color;
        logic     stolen;
    } pix_exp_t;

    typedef struct {
        int       due;
        logic     rd;
        logic [5:0] data;
    } cpu_exp_t;

    logic I_clock = 1'b0;
    logic I_reset = 1'b1;
    video_palette_arbiter_if bus();

    video_palette_arbiter #(.STARVE_MAX(16)) dut (
        .I_clock (I_clock),
        .I_reset (I_reset),
        .bus     (bus)
    );

    always #5 I_clock = ~I_clock;

    int cyc = 0;
    always @(posedge I_clock) cyc <= cyc + 1;

    logic [5:0] ram [32];
    always @(posedge I_clock) begin
        if (I_reset && cyc < 4) begin
            for (int i = 0; i < 32; i++) ram[i] <= 6'((i * 5) + 3);
        end else if (bus.O_pal_wren) begin
            ram[bus.O_pal_addr] <= bus.O_pal_data;
        end
        bus.I_pal_data <= ram[bus.O_pal_addr];
    end

    logic [5:0] ref_pal [32];
    pix_exp_t   pq[$];
    cpu_exp_t   cq[$];
    int vectors = 0;
    int miscompares = 0;
    int stolen_cnt = 0;

    logic       pix_on = 1'b0;
    logic       pix_mode = 1'b0;
    logic [4:0] pix_fixed = 5'h06;
    logic [4:0] seq [5] = '{5'h06, 5'h0C, 5'h07, 5'h1D, 5'h0A};
    int         steal_cyc = -1;
    logic [5:0] last_color = 6'h00;
    logic       ack_seen = 1'b0;
    int         wren_cyc = -1;
    logic [4:0] wren_addr = 5'h00;
    logic [5:0] wren_data = 6'h00;

    function automatic logic [4:0] cpu_map(input logic [4:0] a);
`ifdef VIDEO_PAL_MIRROR_EN
        if (a[4] && a[1:0] == 2'b00) return {1'b0, a[3:0]};
`endif
        return a;
    endfunction

    function automatic logic [4:0] pix_map(input logic [4:0] i);
        return (i[1:0] == 2'b00) ? 5'h00 : i;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    always @(negedge I_clock) begin : monitor
        logic       due_p, due_c;
        logic [5:0] ec;
        logic       es;
        if (!I_reset) begin
            due_p = (pq.size() > 0) && (pq[0].due == cyc);
            es = 1'b0;
            if (due_p) begin
                ec = pq[0].color;
                es = pq[0].stolen;
                pq.pop_front();
                check("pix_color", 32'(bus.O_pix_color), 32'(ec));
            end
            check("pix_valid", 32'(bus.O_pix_valid), 32'(due_p));
            check("pix_stolen", 32'(bus.O_pix_stolen), 32'(es));
            if (bus.O_pix_stolen) stolen_cnt++;

            due_c = (cq.size() > 0) && (cq[0].due == cyc);
            check("cpu_ack", 32'(bus.O_cpu_ack), 32'(due_c));
            if (due_c) begin
                if (cq[0].rd) check("cpu_rdata", 32'(bus.O_cpu_data), 32'(cq[0].data));
                cq.pop_front();
            end
        end
    end

    task automatic tick();
        logic [4:0] idx;
        logic [5:0] col;
        logic       st;
        @(posedge I_clock);
        #1;
        if (bus.O_pal_wren) begin
            wren_cyc  = cyc;
            wren_addr = bus.O_pal_addr;
            wren_data = bus.O_pal_data;
        end
        if (bus.O_cpu_ack) begin
            bus.I_cpu_req = 1'b0;
            ack_seen = 1'b1;
        end
        if (pix_on) begin
            idx = pix_mode ? seq[cyc % 5] : pix_fixed;
            st  = (cyc == steal_cyc);
            col = st ? last_color : ref_pal[pix_map(idx)];
            if (!st) last_color = col;
            bus.I_pix_valid = 1'b1;
            bus.I_pix_index = idx;
            pq.push_back('{due: cyc + 3, color: col, stolen: st});
        end else begin
            bus.I_pix_valid = 1'b0;
        end
    endtask

    // pend = cycles from request until the FSM is granted the slot.
    task automatic cpu_op(input logic wr, input logic [4:0] a, input logic [5:0] d, input int pend);
        int r;
        logic [5:0] rd;
        r  = cyc;
        rd = ref_pal[cpu_map(a)];
        if (wr) ref_pal[cpu_map(a)] = d;
        cq.push_back('{due: r + pend + (wr ? 2 : 3), rd: !wr, data: rd});
        bus.I_cpu_req  = 1'b1;
        bus.I_cpu_wren = wr;
        bus.I_cpu_addr = a;
        bus.I_cpu_data = d;
        ack_seen = 1'b0;
        wren_cyc = -1;
        for (int k = 0; k < 64 && !ack_seen; k++) begin
            tick();
            if (cyc == r + pend) begin
                bus.I_cpu_addr = ~a;
                bus.I_cpu_data = ~d;
                bus.I_cpu_wren = ~wr;
            end
        end
        check("cpu_ack_seen", 32'(ack_seen), 32'd1);
        if (wr) begin
            check("wren_cycle", 32'(wren_cyc), 32'(r + pend + 1));
            check("wren_addr", 32'(wren_addr), 32'(cpu_map(a)));
            check("wren_data", 32'(wren_data), 32'(d));
        end
        bus.I_cpu_req = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"},    32'(bus.O_cpu_ack), 32'd0);
        check({tag, "_cdata"},  32'(bus.O_cpu_data), 32'd0);
        check({tag, "_pvalid"}, 32'(bus.O_pix_valid), 32'd0);
        check({tag, "_pcolor"}, 32'(bus.O_pix_color), 32'd0);
        check({tag, "_stolen"}, 32'(bus.O_pix_stolen), 32'd0);
        check({tag, "_paddr"},  32'(bus.O_pal_addr), 32'd0);
        check({tag, "_pwren"},  32'(bus.O_pal_wren), 32'd0);
        check({tag, "_pdata"},  32'(bus.O_pal_data), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_pal[i] = 6'((i * 5) + 3);
        bus.I_cpu_req   = 1'b0;
        bus.I_cpu_wren  = 1'b0;
        bus.I_cpu_addr  = 5'h00;
        bus.I_cpu_data  = 6'h00;
        bus.I_pix_valid = 1'b1;
        bus.I_pix_index = 5'h06;

        // Reset with the renderer requesting: nothing may come out afterwards.
        repeat (3) @(posedge I_clock);
        #1;
        I_reset = 1'b0;
        bus.I_pix_valid = 1'b0;
        check_zero("reset");
        repeat (4) tick();

        // Write then read back, renderer idle.
        cpu_op(1'b1, 5'h05, 6'h21, 1);
        tick();
        cpu_op(1'b0, 5'h05, 6'h00, 1);
        tick();

        // Continuous render: plain index, backdrop-folded index, then a mixed sequence.
        pix_on = 1'b1;
        pix_mode = 1'b0;
        pix_fixed = 5'h06;
        repeat (8) tick();
        pix_fixed = 5'h0C;
        repeat (8) tick();
        pix_mode = 1'b1;
        repeat (10) tick();

        // Starved CPU read steals the 17th pending slot.
        steal_cyc = cyc + 17;
        cpu_op(1'b0, 5'h0A, 6'h00, 17);
        steal_cyc = -1;
        repeat (6) tick();
        pix_on = 1'b0;
        repeat (5) tick();
        check("stolen_pulses", 32'(stolen_cnt), 32'd1);

        // Back-to-back accesses: write->read and read->write.
        cpu_op(1'b1, 5'h12, 6'h2A, 1);
        cpu_op(1'b0, 5'h12, 6'h00, 2);
        cpu_op(1'b1, 5'h13, 6'h11, 2);
        tick();

        // Mirror addressing (or pass-through without the macro).
        cpu_op(1'b1, 5'h10, 6'h15, 1);
        tick();
        cpu_op(1'b0, 5'h00, 6'h00, 1);
        tick();
        cpu_op(1'b0, 5'h1C, 6'h00, 1);
        tick();

        // Reset while a read sits in WAIT: abandoned, no ack.
        bus.I_cpu_req  = 1'b1;
        bus.I_cpu_wren = 1'b0;
        bus.I_cpu_addr = 5'h05;
        tick();
        tick();
        I_reset = 1'b1;
        bus.I_cpu_req = 1'b0;
        tick();
        check_zero("midreset");
        tick();
        I_reset = 1'b0;
        repeat (5) tick();
        cpu_op(1'b0, 5'h05, 6'h00, 1);

        repeat (6) tick();
        check("pix_queue_drained", 32'(pq.size()), 32'd0);
        check("cpu_queue_drained", 32'(cq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/video_palette_arbiter.md
VIDEO_PALETTE_ARBITER -- requirements
Module: video_palette_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, 16, number of consecutive cycles a pending CPU request may lose to rendering before it steals a slot (range 2..255).
REQ-002 I_clock  in  1  single clock; all logic on its rising edge.
REQ-003 I_reset  in  1  reset, synchronous, active-high.
REQ-004 I_cpu_req  in  1  CPU palette access request; held until O_cpu_ack.
REQ-005 I_cpu_wren  in  1  1 = write, 0 = read; sampled with I_cpu_req.
REQ-006 I_cpu_addr / I_cpu_data  in  5 / 6  CPU palette address and write data.
REQ-007 O_cpu_ack / O_cpu_data  out  1 / 6  one-cycle completion pulse; read data, valid with ack.
REQ-008 I_pix_valid / I_pix_index  in  1 / 5  renderer pixel lookup request, one per cycle maximum.
REQ-009 O_pix_valid / O_pix_color / O_pix_stolen  out  1 / 6 / 1  pixel result; stolen-slot flag.
REQ-010 O_pal_addr / O_pal_wren / O_pal_data  out  5 / 1 / 6  registered palette RAM port.
REQ-011 I_pal_data  in  6  palette RAM read data, valid one cycle after O_pal_addr.

Function
REQ-012 Each cycle exactly one palette slot is granted: renderer if I_pix_valid and starvation counter < STARVE_MAX, else pending CPU request, else idle (O_pal_wren=0, address held).
REQ-013 Render pipeline: request in cycle N -> O_pal_addr at N+1 -> I_pal_data at N+2 -> O_pix_valid/O_pix_color registered at N+3; fixed 3-cycle latency.
REQ-014 Pixel index with low two bits 00 shall be looked up at address 0x00 (backdrop) regardless of bits 4:2.
REQ-015 CPU FSM states: IDLE, ISSUE, WAIT, ACK. IDLE->ISSUE on I_cpu_req; ISSUE->WAIT when slot granted; WAIT->ACK after one cycle; ACK->IDLE unconditionally.
REQ-016 CPU write: O_pal_wren=1 only in the granted cycle; ack at grant+2. CPU read: ack at grant+3 with O_cpu_data = I_pal_data captured at grant+2.
REQ-017 CPU request fields latched on IDLE->ISSUE; changes to I_cpu_* while not IDLE are ignored.
REQ-018 Starvation counter increments each cycle in ISSUE when renderer wins, clears on CPU grant or in IDLE, saturates at STARVE_MAX.
REQ-019 Stolen slot: when counter = STARVE_MAX and I_pix_valid, CPU is granted; that pixel emerges at N+3 with O_pix_valid=1, O_pix_color = last delivered color, O_pix_stolen=1.
REQ-020 Back-to-back CPU requests: a new request is accepted no earlier than the cycle after ACK (minimum 4-cycle spacing).
REQ-021 O_cpu_ack and O_pix_stolen shall be single-cycle pulses.

Reset
REQ-022 On I_reset: FSM=IDLE, counter=0, pipeline flushed, all outputs 0 the following cycle; an in-flight CPU access is abandoned with no ack.
REQ-023 I_pix_valid asserted during reset shall produce no O_pix_valid.

Configuration
REQ-024 Macro VIDEO_PAL_MIRROR_EN defined: CPU addresses 0x10/0x14/0x18/0x1C map to 0x00/0x04/0x08/0x0C for both reads and writes.
REQ-025 Macro undefined: CPU addresses pass through unmodified; renderer behaviour (REQ-014) unchanged.

Structure
REQ-026 Shared package video_pkg: palette address/color widths (5, 6), cpu FSM state enum, backdrop address constant 0x00.
REQ-027 Address-remap logic (mirror + backdrop) in sub-module video_palette_remap, purely combinational; all other logic in this module.

Verification
REQ-028 CPU write 0x21 to 0x05, render idle -> O_pal_wren=1 addr 0x05 at grant, ack 2 cycles later; subsequent read of 0x05 returns 0x21 with ack.
REQ-029 Continuous I_pix_valid with index 0x06 -> O_pix_valid every cycle, 3-cycle latency, color = RAM[0x06]; index 0x0C -> color = RAM[0x00].
REQ-030 CPU read pending under continuous render, STARVE_MAX=16 -> grant in 17th pending cycle, exactly one O_pix_stolen pulse, repeated previous color.
REQ-031 With VIDEO_PAL_MIRROR_EN: write 0x15 to 0x10 -> read 0x00 returns 0x15; without macro -> read 0x00 unchanged.
REQ-032 Reset asserted in WAIT of a CPU read -> no O_cpu_ack, all outputs 0 next cycle, new request after reset completes normally.
